// File: rtl/master_tx_pkg.sv
// Shared definitions for the burst transmit master: FSM state encoding,
// instruction encodings, default parameter values and a small helper.
package master_tx_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BURST_W = 12;
  localparam int DEF_SLV_W   = 2;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    HDR      = 3'd2,
    WAIT_SLV = 3'd3,
    WDATA    = 3'd4,
    RDATA    = 3'd5,
    DONE     = 3'd6
  } state_t;

  // 2'b01 is reserved and behaves like idle.
  typedef enum logic [1:0] {
    INSTR_IDLE  = 2'b00,
    INSTR_RSVD  = 2'b01,
    INSTR_WRITE = 2'b10,
    INSTR_READ  = 2'b11
  } instr_t;

  // Header length is set by the widest of the three serial header fields.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register, LSB first. Load wins over shift;
// zeros are shifted in so the line idles low once the field is exhausted.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  output logic         sout
);

  logic [W-1:0] sr;

  // Load a new word or shift one bit toward the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_val;
    end else if (shift_en) begin
      sr <= sr >> 1;
    end
  end

  assign sout = sr[0];

endmodule

// File: rtl/master_burst_tx.sv
// Burst transmit master: arbitrates for the bus, serialises a header
// (slave select, address, burst count) and then either serialises write
// beats or counts received read beats.
// Optional feature: define MASTER_TX_TIMEOUT_EN to abort when the slave
// does not answer the header within TIMEOUT cycles.
module master_burst_tx
  import master_tx_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int SLV_W   = DEF_SLV_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         instruction,
  input  logic [SLV_W-1:0]   slave_select,
  input  logic [ADDR_W-1:0]  address,
  input  logic [BURST_W-1:0] burst_num,
  input  logic [DATA_W-1:0]  data,
  input  logic               busy,
  input  logic               approval_grant,
  input  logic               slave_ready,
  input  logic               rx_done,
  output logic               approval_request,
  output logic               tx_slave_select,
  output logic               tx_address,
  output logic               tx_burst_number,
  output logic               tx_data,
  output logic               master_valid,
  output logic               master_ready,
  output logic               write_en,
  output logic               read_en,
  output logic               data_req,
  output logic               tx_done,
  output logic               tx_err
);

  localparam int HDR_LEN = max3(SLV_W, ADDR_W, BURST_W);
  localparam int HDR_CW  = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
  localparam int BIT_CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [HDR_CW-1:0] HDR_LAST = HDR_CW'(HDR_LEN - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);

  state_t state, state_nxt;

  instr_t             inst_q;
  logic [SLV_W-1:0]   slv_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] burst_q;

  logic [HDR_CW-1:0]  hdr_cnt;
  logic [BIT_CW-1:0]  bit_cnt;
  // One extra bit so an all-ones burst count (2^BURST_W beats) cannot wrap.
  logic [BURST_W:0]   beat_cnt;

  logic start;
  logic is_write;
  logic is_read;
  logic in_xfer;
  logic last_beat;
  logic bit_first;
  logic beat_inc;
  logic abort;
  logic timeout_hit;

  logic hdr_load;
  logic hdr_shift;
  logic sel_bit;
  logic addr_bit;
  logic burst_bit;
  logic data_bit;

  assign start     = ((instruction == INSTR_WRITE) || (instruction == INSTR_READ)) && !busy;
  assign is_write  = (inst_q == INSTR_WRITE);
  assign is_read   = (inst_q == INSTR_READ);
  assign in_xfer   = (state == HDR) || (state == WAIT_SLV) || (state == WDATA) ||
                     (state == RDATA) || (state == DONE);
  assign bit_first = (bit_cnt == '0);
  assign last_beat = (beat_cnt == {1'b0, burst_q});
  assign beat_inc  = ((state == WDATA) && (bit_cnt == BIT_LAST)) ||
                     ((state == RDATA) && rx_done);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the transaction descriptor on acceptance; held until IDLE again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q  <= INSTR_IDLE;
      slv_q   <= '0;
      addr_q  <= '0;
      burst_q <= '0;
    end else if ((state == IDLE) && start) begin
      inst_q  <= instr_t'(instruction);
      slv_q   <= slave_select;
      addr_q  <= address;
      burst_q <= burst_num;
    end
  end

  // Header bit counter, data bit counter within a beat, and beat counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_cnt  <= '0;
      bit_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      hdr_cnt <= (state == HDR) ? hdr_cnt + 1'b1 : '0;
      if (state == WDATA) begin
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
      if (state == IDLE) begin
        beat_cnt <= '0;
      end else if (beat_inc) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef MASTER_TX_TIMEOUT_EN
  localparam int TO_CW = $clog2(TIMEOUT + 1);
  localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TIMEOUT - 1);

  logic [TO_CW-1:0] wait_cnt;

  // Count consecutive cycles spent waiting for the slave to accept the header.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= (state == WAIT_SLV) ? wait_cnt + 1'b1 : '0;
    end
  end

  assign timeout_hit = (wait_cnt == TO_LAST);
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and control outputs; losing the grant mid-transfer aborts.
  always_comb begin
    state_nxt        = state;
    approval_request = (state != IDLE);
    write_en         = in_xfer && is_write;
    read_en          = in_xfer && is_read;
    master_valid     = 1'b0;
    master_ready     = 1'b0;
    data_req         = 1'b0;
    tx_done          = 1'b0;
    tx_err           = 1'b0;
    abort            = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = REQ;
      end
      REQ: begin
        if (approval_grant) state_nxt = HDR;
      end
      HDR: begin
        master_valid = 1'b1;
        if (!approval_grant)          abort     = 1'b1;
        else if (hdr_cnt == HDR_LAST) state_nxt = WAIT_SLV;
      end
      WAIT_SLV: begin
        if (!approval_grant)  abort     = 1'b1;
        else if (slave_ready) state_nxt = is_write ? WDATA : RDATA;
        else if (timeout_hit) abort     = 1'b1;
      end
      WDATA: begin
        master_valid = 1'b1;
        data_req     = bit_first && approval_grant;
        if (!approval_grant)                         abort     = 1'b1;
        else if ((bit_cnt == BIT_LAST) && last_beat) state_nxt = DONE;
      end
      RDATA: begin
        master_ready = 1'b1;
        if (!approval_grant)           abort     = 1'b1;
        else if (rx_done && last_beat) state_nxt = DONE;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      tx_err    = 1'b1;
      state_nxt = IDLE;
    end
  end

  assign hdr_load  = (state == REQ) && approval_grant;
  assign hdr_shift = (state == HDR);

  piso_shift #(.W(SLV_W)) u_sel_sr (
    .clk      (clk),
    .rst_n    (reset),
    .load     (hdr_load),
    .load_val (slv_q),
    .shift_en (hdr_shift),
    .sout     (sel_bit)
  );

  piso_shift #(.W(ADDR_W)) u_addr_sr (
    .clk      (clk),
    .rst_n    (reset),
    .load     (hdr_load),
    .load_val (addr_q),
    .shift_en (hdr_shift),
    .sout     (addr_bit)
  );

  piso_shift #(.W(BURST_W)) u_burst_sr (
    .clk      (clk),
    .rst_n    (reset),
    .load     (hdr_load),
    .load_val (burst_q),
    .shift_en (hdr_shift),
    .sout     (burst_bit)
  );

  // Bit 0 of a beat goes out straight from the data input in the sample
  // cycle, so only the upper bits are loaded; this keeps beats gap-free.
  piso_shift #(.W(DATA_W)) u_data_sr (
    .clk      (clk),
    .rst_n    (reset),
    .load     (data_req),
    .load_val ({1'b0, data[DATA_W-1:1]}),
    .shift_en ((state == WDATA) && !bit_first),
    .sout     (data_bit)
  );

  assign tx_slave_select = hdr_shift & sel_bit;
  assign tx_address      = hdr_shift & addr_bit;
  assign tx_burst_number = hdr_shift & burst_bit;
  assign tx_data         = (state == WDATA) & (bit_first ? data[0] : data_bit);

endmodule

// File: doc/master_burst_tx.md
MASTER_BURST_TX -- requirements
Module: master_burst_tx

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, address width; DATA_W, default 8, data width; BURST_W, default 12, burst-count width; SLV_W, default 2, slave-select width; TIMEOUT, default 64, slave-ready timeout in cycles.
REQ-002 Ports SHALL be as follows; one clock, reset asynchronous active-low:
- clk  in  1  clock
- reset  in  1  async active-low reset
- instruction  in  2  00 idle, 10 write, 11 read, 01 reserved (treated as idle)
- slave_select  in  SLV_W  target slave
- address  in  ADDR_W  start address
- burst_num  in  BURST_W  extra beats; beats = burst_num+1
- data  in  DATA_W  write word for the current beat
- busy  in  1  bus occupied
- approval_grant  in  1  arbiter grant
- slave_ready  in  1  slave accepted header
- rx_done  in  1  one read beat received
- approval_request  out  1  arbiter request
- tx_slave_select  out  1  serial slave select, LSB first
- tx_address  out  1  serial address, LSB first
- tx_burst_number  out  1  serial burst count, LSB first
- tx_data  out  1  serial write data, LSB first
- master_valid  out  1  serial output bit valid
- master_ready  out  1  master accepting read beats
- write_en  out  1  write transaction active
- read_en  out  1  read transaction active
- data_req  out  1  write word sampled this cycle
- tx_done  out  1  one-cycle completion pulse
- tx_err  out  1  one-cycle abort pulse

Function
REQ-003 FSM states SHALL be IDLE, REQ, HDR, WAIT_SLV, WDATA, RDATA, DONE.
REQ-004 IDLE: if instruction is 10 or 11 and busy is 0, the block SHALL latch instruction, slave_select, address and burst_num, then go to REQ; latched values SHALL NOT change until IDLE is re-entered.
REQ-005 REQ: approval_request SHALL be 1 from REQ through DONE; on approval_grant=1 the FSM SHALL go to HDR on the next edge.
REQ-006 HDR SHALL last max(SLV_W,ADDR_W,BURST_W) cycles; the three header fields SHALL shift concurrently, one bit per cycle, and a line SHALL be 0 after its field is exhausted; master_valid SHALL be 1 throughout HDR.
REQ-007 WAIT_SLV: on slave_ready=1 the FSM SHALL go to WDATA if the latched instruction is write, otherwise to RDATA.
REQ-008 WDATA: each beat SHALL sample data and pulse data_req in its first cycle, then shift DATA_W bits on tx_data with master_valid=1; beats SHALL run back-to-back with no gap cycle.
REQ-009 RDATA: master_ready SHALL be 1; each cycle with rx_done=1 SHALL count one beat.
REQ-010 The beat counter SHALL be BURST_W+1 bits wide so that burst_num all-ones (2^BURST_W beats) does not wrap; after beat burst_num+1 the FSM SHALL go to DONE.
REQ-011 DONE SHALL last one cycle with tx_done=1, then the FSM SHALL go to IDLE with approval_request, write_en, read_en, master_valid and master_ready all 0.
REQ-012 write_en SHALL be 1 from HDR through DONE for writes; read_en SHALL be 1 from HDR through DONE for reads.
REQ-013 approval_grant falling in any state HDR through RDATA SHALL abort: one cycle with tx_err=1, then IDLE; tx_done SHALL NOT pulse.
REQ-014 instruction changes after latching SHALL be ignored; rx_done outside RDATA SHALL be ignored.

Reset
REQ-015 reset=0 SHALL asynchronously force IDLE, clear all counters and shift registers, and drive every output to 0, including mid-transfer.
REQ-016 The first transaction SHALL be accepted on the first edge after reset release.

Configuration
REQ-017 With MASTER_TX_TIMEOUT_EN defined, TIMEOUT consecutive cycles in WAIT_SLV without slave_ready SHALL abort as in REQ-013.
REQ-018 Without MASTER_TX_TIMEOUT_EN, WAIT_SLV SHALL wait indefinitely, and tx_err SHALL pulse only on grant loss.

Structure
REQ-019 Package master_tx_pkg SHALL hold the FSM state enum, the instruction encodings (IDLE, WRITE, READ) and the default parameter constants.
REQ-020 Sub-module piso_shift (parameterised width, load, shift enable, serial out, LSB first) SHALL be instantiated four times: slave select, address, burst count, data.

Verification
REQ-021 Write: slave_select=2, address=12'h553, burst_num=0, data=8'hA5; grant after 2 cycles, slave_ready after HDR -> 12 HDR cycles, tx_data bits 1,0,1,0,0,1,0,1, one data_req, tx_done one cycle later.
REQ-022 Read: slave_select=3, burst_num=3, rx_done pulsed 4 times -> master_ready and read_en high until the 4th rx_done, then tx_done for exactly 1 cycle.
REQ-023 busy=1 with instruction=11 -> approval_request stays 0 until busy=0, and is 1 on the following cycle.
REQ-024 approval_grant dropped in the 5th HDR cycle -> tx_err one cycle, IDLE, all outputs 0, no tx_done.
REQ-025 reset=0 mid-WDATA -> all outputs 0 asynchronously; after release a new write completes normally.
REQ-026 With MASTER_TX_TIMEOUT_EN and TIMEOUT=64, slave_ready held 0 -> tx_err at WAIT_SLV cycle 64; without the macro, no tx_err after 1000 cycles.
